alu_ctrl_fsm: RTL

- Multicycle CPU control unit; it is the initiator side of the ALU interface.
- Decodes the instruction register, sequences FETCH/DECODE/EXEC/MEM/WB, and drives the ALU command and operand selects.
- Consumes the ALU zero flag for branches and drives all datapath write enables and mux selects.
- Sits between the IR and the datapath (PC, memory, regfile, ALU, ALUOut and MDR registers).

---
 rtl/alu_ctrl_fsm.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/alu_ctrl_fsm.sv
// alu_ctrl_fsm: multicycle CPU control unit.
// Decodes the IR, steps through FETCH/DECODE/EXEC/MEM/WB and drives the ALU
// command, operand selects, datapath write enables and mux selects.
module alu_ctrl_fsm #(
  parameter int CNT_W           = 32,
  parameter bit HALT_ON_ILLEGAL = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      instr,
  input  logic             zero,
  output logic [2:0]       state,
  output logic             pc_we,
  output logic             ir_we,
  output logic             mem_we,
  output logic             reg_we,
  output logic             iord,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [2:0]       alu_cmd,
  output logic [1:0]       reg_dst,
  output logic [1:0]       wb_sel,
  output logic [1:0]       pc_src,
  output logic             retire,
  output logic [CNT_W-1:0] instr_cnt,
  output logic             illegal
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [2:0] CMD_ADD  = 3'd0;
  localparam logic [2:0] CMD_SUB  = 3'd1;
  localparam logic [2:0] CMD_XOR  = 3'd2;
  localparam logic [2:0] CMD_SLT  = 3'd3;
  localparam logic [2:0] CMD_AND  = 3'd4;
  localparam logic [2:0] CMD_NOR  = 3'd6;
  localparam logic [2:0] CMD_OR   = 3'd7;

  state_t     cur, nxt;
  logic [5:0] op, funct;
  logic       is_lw, is_sw, is_addi, is_beq, is_bne, is_j, is_jal, is_jr;
  logic       is_ralu, is_legal;
  logic [2:0] r_cmd;
  logic       pc_we_c, ir_we_c, mem_we_c, reg_we_c, retire_c;

  // Register/target fields are consumed by the datapath, not by control.
  logic unused_fields;
  assign unused_fields = ^instr[25:6];

  assign op    = instr[31:26];
  assign funct = instr[5:0];
  assign state = cur;

  // Instruction class decode; only meaningful from DECODE onward.
  always_comb begin
    is_lw   = (op == OP_LW);
    is_sw   = (op == OP_SW);
    is_addi = (op == OP_ADDI);
    is_beq  = (op == OP_BEQ);
    is_bne  = (op == OP_BNE);
    is_j    = (op == OP_J);
    is_jal  = (op == OP_JAL);
    is_jr   = (op == OP_RTYPE) && (funct == 6'h08);
    is_ralu = 1'b0;
    r_cmd   = CMD_ADD;
    if (op == OP_RTYPE) begin
      is_ralu = 1'b1;
      case (funct)
        6'h20:   r_cmd = CMD_ADD;
        6'h22:   r_cmd = CMD_SUB;
        6'h24:   r_cmd = CMD_AND;
        6'h25:   r_cmd = CMD_OR;
        6'h26:   r_cmd = CMD_XOR;
        6'h27:   r_cmd = CMD_NOR;
        6'h2A:   r_cmd = CMD_SLT;
        default: is_ralu = 1'b0;
      endcase
    end
    is_legal = is_lw | is_sw | is_addi | is_beq | is_bne | is_j | is_jal |
               is_jr | is_ralu;
  end

  // State register; reset aborts any in-flight instruction.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cur <= S_FETCH;
    else       cur <= nxt;
  end

  // Retired-instruction counter, wraps freely.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       instr_cnt <= '0;
    else if (retire) instr_cnt <= instr_cnt + CNT_W'(1);
  end

  // Next-state and control decode for the current state.
  always_comb begin
    nxt       = cur;
    pc_we_c   = 1'b0;
    ir_we_c   = 1'b0;
    mem_we_c  = 1'b0;
    reg_we_c  = 1'b0;
    retire_c  = 1'b0;
    iord      = 1'b0;
    alu_src_a = 1'b0;
    alu_src_b = 2'd0;
    alu_cmd   = CMD_ADD;
    reg_dst   = 2'd0;
    wb_sel    = 2'd0;
    pc_src    = 2'd0;
    illegal   = 1'b0;
    case (cur)
      S_FETCH: begin
        ir_we_c   = 1'b1;
        alu_src_b = 2'd1;
        pc_we_c   = 1'b1;
        nxt       = S_DECODE;
      end
      S_DECODE: begin
        // ALU computes the branch target for ALUOut in the background.
        alu_src_b = 2'd3;
        if (is_j || is_jal) begin
          pc_src   = 2'd2;
          pc_we_c  = 1'b1;
          retire_c = 1'b1;
          nxt      = S_FETCH;
          if (is_jal) begin
            // PC already holds PC+4 after FETCH, so that is the link value.
            reg_we_c = 1'b1;
            reg_dst  = 2'd2;
            wb_sel   = 2'd2;
          end
        end else if (is_jr) begin
          pc_src   = 2'd3;
          pc_we_c  = 1'b1;
          retire_c = 1'b1;
          nxt      = S_FETCH;
        end else if (!is_legal) begin
          nxt = HALT_ON_ILLEGAL ? S_HALT : S_FETCH;
        end else begin
          nxt = S_EXEC;
        end
      end
      S_EXEC: begin
        alu_src_a = 1'b1;
        nxt       = S_FETCH;
        if (is_lw || is_sw || is_addi) begin
          alu_src_b = 2'd2;
          nxt       = is_addi ? S_WB : S_MEM;
        end else if (is_ralu) begin
          alu_cmd = r_cmd;
          nxt     = S_WB;
        end else if (is_beq || is_bne) begin
          alu_cmd  = CMD_SUB;
          pc_src   = 2'd1;
          pc_we_c  = is_beq ? zero : ~zero;
          retire_c = 1'b1;
        end
      end
      S_MEM: begin
        iord = 1'b1;
        if (is_sw) begin
          mem_we_c = 1'b1;
          retire_c = 1'b1;
          nxt      = S_FETCH;
        end else begin
          nxt = S_WB;
        end
      end
      S_WB: begin
        reg_we_c = 1'b1;
        retire_c = 1'b1;
        nxt      = S_FETCH;
        if (is_ralu)    reg_dst = 2'd1;
        else if (is_lw) wb_sel  = 2'd1;
      end
      S_HALT: begin
        illegal = 1'b1;
        nxt     = S_HALT;
      end
      default: nxt = S_FETCH;
    endcase
  end

  // Enables and retire are held off for as long as reset is asserted.
  always_comb begin
    pc_we  = pc_we_c  & ~reset;
    ir_we  = ir_we_c  & ~reset;
    mem_we = mem_we_c & ~reset;
    reg_we = reg_we_c & ~reset;
    retire = retire_c & ~reset;
  end

endmodule
